// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the multi-cycle data-memory responder
//   state_t     responder FSM states in a 2-bit encoding
//   MEM_WORD_W  memory word width
//   LAT_DEF     default response latency in cycles
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam int MEM_WORD_W = 16;
    localparam int LAT_DEF = 4;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU load/store request/response bus
//   master: req_valid, req_wr, req_addr, req_wdata out; req_ready, resp_valid, resp_rdata, busy (err) in
//   slave:  the mirror image, used by mem_responder
//   err exists only when MEM_MISALIGN_CHK_EN is defined
interface mem_responder_if #(
    parameter int ADDR_W = 16
);
    import mem_pkg::*;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_W-1:0]     req_addr;
    logic [MEM_WORD_W-1:0] req_wdata;
    logic                  resp_valid;
    logic [MEM_WORD_W-1:0] resp_rdata;
    logic                  busy;
`ifdef MEM_MISALIGN_CHK_EN
    logic                  err;
`endif
    modport master(
        output req_valid, req_wr, req_addr, req_wdata,
`ifdef MEM_MISALIGN_CHK_EN
        input  err,
`endif
        input  req_ready, resp_valid, resp_rdata, busy
    );
    modport slave(
        input  req_valid, req_wr, req_addr, req_wdata,
`ifdef MEM_MISALIGN_CHK_EN
        output err,
`endif
        output req_ready, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH x MEM_WORD_W storage, synchronous write, asynchronous read
//   clk          write clock
//   we/waddr/wdata  write port, committed on the rising edge
//   raddr/rdata  combinational read port
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [MEM_WORD_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [MEM_WORD_W-1:0] rdata
);
    logic [MEM_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle 16-bit data-memory responder answering each request exactly LAT cycles after acceptance
//   clk    system clock
//   rst_n  asynchronous active-low reset (array contents are kept)
//   bus    mem_responder_if.slave: valid/ready request, one-cycle resp_valid pulse, busy stall flag
//   Optional MEM_MISALIGN_CHK_EN: odd addresses complete with err=1, no write and zero read data
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int LAT    = LAT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    state_t                state, nxt;
    logic [3:0]            cnt, nxt_cnt;
    logic                  wr_q, mis_q, mis_in, accept;
    logic [IW-1:0]         idx_q;
    logic [MEM_WORD_W-1:0] wdata_q, rdata;
    logic                  unused_bits;

    assign accept      = bus.req_valid && bus.req_ready;
    assign unused_bits = ^{bus.req_addr[ADDR_W-1:IW+1], bus.req_addr[0]};

`ifdef MEM_MISALIGN_CHK_EN
    assign mis_in  = bus.req_addr[0];
    assign bus.err = bus.resp_valid && mis_q;
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        nxt_cnt = cnt;
        if (accept) begin
            nxt     = (LAT == 1) ? RESP : BUSY;
            nxt_cnt = (LAT == 1) ? 4'd0 : 4'(LAT - 1);
        end else if (state == BUSY) begin
            nxt_cnt = cnt - 4'd1;
            nxt     = (cnt == 4'd1) ? RESP : BUSY;
        end else if (state == RESP) begin
            nxt = IDLE;
        end
    end

    // Outputs are registered from the next state so they are glitch-free flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            wr_q           <= 1'b0;
            mis_q          <= 1'b0;
            idx_q          <= '0;
            wdata_q        <= '0;
        end else begin
            state          <= nxt;
            cnt            <= nxt_cnt;
            bus.req_ready  <= nxt != BUSY;
            bus.busy       <= nxt == BUSY;
            bus.resp_valid <= nxt == RESP;
            if (accept) begin
                wr_q    <= bus.req_wr;
                mis_q   <= mis_in;
                idx_q   <= bus.req_addr[IW:1];
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // The array is read in the response cycle itself, so a read accepted during a
    // write's response cycle sees the freshly committed data. Reset drops resp_valid
    // asynchronously, which also cancels a pending write.
    assign bus.resp_rdata = (bus.resp_valid && !wr_q && !mis_q) ? rdata : '0;

    mem_array #(.DEPTH(DEPTH)) u_array (
        .clk  (clk),
        .we   (bus.resp_valid && wr_q && !mis_q),
        .waddr(idx_q),
        .wdata(wdata_q),
        .raddr(idx_q),
        .rdata(rdata)
    );
endmodule
